y86_pc_sequencer: RTL and testbench
===================================

Name: y86_pc_sequencer

Overview:
Parametrised successor to the instruction counter. Computes the next program counter from the decoded icode each accepted instruction:
- sequential advance by instruction length
- conditional/unconditional jumps
- call/ret through an internal return-address stack (RAS)
- halt and error states

Sits between fetch/decode and the instruction memory address port.

Parameters:
ADDR_W, 16, PC width in bits; all PC arithmetic is modulo 2^ADDR_W.
RESET_PC, 0, PC value loaded on reset.
RAS_DEPTH, 4, number of return-address stack entries (>=1).
COUNT_W, 32, width of retired-instruction counter (optional feature only).

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
icode_input  in  4  decoded icode of the current instruction.
valC_input  in  ADDR_W  jump/call destination.
cond_true  in  1  jXX condition result, evaluated externally from ifun and the condition codes.
instr_valid  in  1  icode_input/valC_input valid this cycle.
stall  in  1  hold the PC; has priority over instr_valid.
pc  out  ADDR_W  current program counter.
status  out  2  00 AOK, 01 HLT, 10 INS (illegal icode), 11 STK (RAS over/underflow).
ras_depth  out  $clog2(RAS_DEPTH+1)  occupied RAS entries.
retired_count  out  COUNT_W  present only with the optional feature.

Behaviour:
- Reset (reset=0, asynchronous): pc=RESET_PC, status=00, ras_depth=0, state RUN. Takes effect immediately, including mid-operation. RAS contents are don't-care after reset.
- States: RUN, HALT, ERROR. status encodes the state and the error cause. HALT and ERROR are absorbing until reset.
- Accept condition: state RUN & instr_valid=1 & stall=0. Nothing changes in a cycle without accept.
- Latency: pc, status and ras_depth update on the rising edge ending the accept cycle, so the new pc is visible one cycle later. One instruction per cycle maximum.
- Length table (bytes):
  - 0 halt=1, 1 nop=1, 9 ret=1
  - 2 rrmovq/cmov=2, 6 OPq=2, A pushq=2, B popq=2
  - 3 irmovq=10, 4 rmmovq=10, 5 mrmovq=10
  - 7 jXX=9, 8 call=9
- Next-PC rules:
  - icode 1-6, A, B: pc <= pc+len.
  - 0 halt: pc holds; -> HALT, status=01.
  - 7 jXX: pc <= cond_true ? valC_input : pc+9.
  - 8 call: if ras_depth<RAS_DEPTH: push pc+9, pc <= valC_input, ras_depth+1. Else pc holds, no push, -> ERROR, status=11.
  - 9 ret: if ras_depth>0: pc <= popped value, ras_depth-1. Else pc holds, -> ERROR, status=11.
  - C-F: pc holds; -> ERROR, status=10.
- Wrap-around: pc+len truncated to ADDR_W bits with no flag; the pushed return address is also truncated.
- RAS is LIFO: push writes entry[ras_depth], pop reads entry[ras_depth-1]. The maximum one RAS operation per cycle rule makes push and pop in the same cycle impossible.
- stall=1 with instr_valid=1: full hold; the instruction must be re-presented.
- In HALT/ERROR: pc, status and RAS frozen; instr_valid ignored.

Optional Feature:
Macro PC_RETIRED_COUNT_EN.
- Defined: retired_count port exists, reset to 0. It increments by 1 on every accept whose result is not ERROR; halt counts as retired. Wraps modulo 2^COUNT_W. Frozen in HALT/ERROR.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
All scenarios use ADDR_W=16, RESET_PC=0, RAS_DEPTH=4.
1. Release reset; accept nop, irmovq, OPq -> pc 0x0000 -> 0x0001 -> 0x000B -> 0x000D, each new value one cycle after its accept; status=00.
2. At pc 0x000D: jXX valC=0x0040 cond_true=0 -> 0x0016. Then jXX valC=0x0040 cond_true=1 -> 0x0040.
3. At 0x0040: call valC=0x0100 -> pc 0x0100, ras_depth=1. Then ret -> pc 0x0049, ras_depth=0. Then ret on empty RAS -> status=11, pc stays 0x0049. Subsequent valid nop is ignored.
4. Five nested calls (valC 0x1000, 0x2000, 0x3000, 0x4000, 0x5000) -> after the fourth, pc=0x4000, ras_depth=4. The fifth -> status=11, pc stays 0x4000, ras_depth=4.
5. stall=1 for 3 cycles with instr_valid=1, icode=3 at pc 0xFFFE -> pc unchanged. Drop stall -> pc=0x0008 (wrap). Then icode=0xD -> status=10, pc holds 0x0008.
6. Accept halt at pc 0x0008 -> status=01, pc holds. Assert reset low mid-cycle -> pc=0x0000, status=00 before the next clock edge. With PC_RETIRED_COUNT_EN, retired_count returns to 0.

Source files
------------

// File: rtl/y86_pc_sequencer.sv
// Y86 next-PC sequencer: sequential advance, jumps, call/ret via a return-address stack, halt/error states.
// Optional retired-instruction counter enabled by defining PC_RETIRED_COUNT_EN.
module y86_pc_sequencer #(
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                RAS_DEPTH = 4,
    parameter int                COUNT_W   = 32
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [3:0]                         icode_input,
    input  logic [ADDR_W-1:0]                  valC_input,
    input  logic                               cond_true,
    input  logic                               instr_valid,
    input  logic                               stall,
    output logic [ADDR_W-1:0]                  pc,
    output logic [1:0]                         status,
    output logic [$clog2(RAS_DEPTH+1)-1:0]     ras_depth
`ifdef PC_RETIRED_COUNT_EN
    ,
    output logic [COUNT_W-1:0]                 retired_count
`endif
);

    localparam int DW = $clog2(RAS_DEPTH + 1);
    localparam int IW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [DW-1:0] RAS_FULL = DW'(RAS_DEPTH);

    if (RAS_DEPTH < 1 || COUNT_W < 1) begin : g_param_check
        $error("y86_pc_sequencer: RAS_DEPTH and COUNT_W must be at least 1");
    end

    // The state encoding doubles as the status code, so ERROR is split by cause.
    typedef enum logic [1:0] {
        ST_RUN = 2'b00,
        ST_HLT = 2'b01,
        ST_INS = 2'b10,
        ST_STK = 2'b11
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DW-1:0]     depth_q, depth_d;
    logic [ADDR_W-1:0] ras_mem [2**IW];
    logic [ADDR_W-1:0] pc_seq;
    logic [ADDR_W-1:0] ras_top;
    logic [IW-1:0]     push_idx;
    logic [IW-1:0]     pop_idx;
    logic              accept;
    logic              push;

    function automatic logic [3:0] instr_len(input logic [3:0] ic);
        case (ic)
            4'h3, 4'h4, 4'h5:       return 4'd10;
            4'h7, 4'h8:             return 4'd9;
            4'h2, 4'h6, 4'hA, 4'hB: return 4'd2;
            default:                return 4'd1;
        endcase
    endfunction

    assign accept   = (state_q == ST_RUN) && instr_valid && !stall;
    assign pc_seq   = pc_q + ADDR_W'(instr_len(icode_input));
    assign push_idx = IW'(depth_q);
    assign pop_idx  = IW'(depth_q - DW'(1));
    assign ras_top  = ras_mem[pop_idx];

    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        depth_d = depth_q;
        push    = 1'b0;
        if (accept) begin
            case (icode_input)
                4'h0: state_d = ST_HLT;
                4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: pc_d = pc_seq;
                4'h7: pc_d = cond_true ? valC_input : pc_seq;
                4'h8: begin
                    if (depth_q < RAS_FULL) begin
                        push    = 1'b1;
                        pc_d    = valC_input;
                        depth_d = depth_q + DW'(1);
                    end else begin
                        state_d = ST_STK;
                    end
                end
                4'h9: begin
                    if (depth_q != '0) begin
                        pc_d    = ras_top;
                        depth_d = depth_q - DW'(1);
                    end else begin
                        state_d = ST_STK;
                    end
                end
                default: state_d = ST_INS;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            depth_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            depth_q <= depth_d;
        end
    end

    // NOTE: the stack storage has no reset; ras_depth alone defines which entries are meaningful.
    always_ff @(posedge clock) begin
        if (push) begin
            ras_mem[push_idx] <= pc_seq;
        end
    end

`ifdef PC_RETIRED_COUNT_EN
    logic [COUNT_W-1:0] count_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (accept && (state_d == ST_RUN || state_d == ST_HLT)) begin
            count_q <= count_q + COUNT_W'(1);
        end
    end

    assign retired_count = count_q;
`endif

    assign pc        = pc_q;
    assign status    = state_q;
    assign ras_depth = depth_q;

endmodule

// File: tb/tb_y86_pc_sequencer.sv
// Directed bench for y86_pc_sequencer (ADDR_W=16, RESET_PC=0, RAS_DEPTH=4).
// Retired-count checks compile in only when PC_RETIRED_COUNT_EN is defined.
module tb_y86_pc_sequencer;

    logic        clock;
    logic        reset;
    logic [3:0]  icode;
    logic [15:0] valc;
    logic        cond;
    logic        valid;
    logic        stall;
    logic [15:0] pc;
    logic [1:0]  status;
    logic [2:0]  depth;
`ifdef PC_RETIRED_COUNT_EN
    logic [31:0] retired;
`endif

    int checks = 0;
    int errors = 0;

    y86_pc_sequencer #(
        .ADDR_W   (16),
        .RESET_PC (16'h0000),
        .RAS_DEPTH(4),
        .COUNT_W  (32)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .icode_input  (icode),
        .valC_input   (valc),
        .cond_true    (cond),
        .instr_valid  (valid),
        .stall        (stall),
        .pc           (pc),
        .status       (status),
        .ras_depth    (depth)
`ifdef PC_RETIRED_COUNT_EN
        ,
        .retired_count(retired)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Present one instruction for a single cycle; outputs are sampled 1 time unit after the edge.
    task automatic issue(input logic [3:0] ic, input logic [15:0] vc, input logic c);
        @(negedge clock);
        icode = ic;
        valc  = vc;
        cond  = c;
        valid = 1'b1;
        stall = 1'b0;
        @(posedge clock);
        #1;
        valid = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h want %h", pc, 16'h0000); end
        checks++; if (status !== 2'b00) begin errors++; $display("FAIL reset_status: got %b want %b", status, 2'b00); end
        checks++; if (depth !== 3'd0) begin errors++; $display("FAIL reset_depth: got %0d want %0d", depth, 0); end
`ifdef PC_RETIRED_COUNT_EN
        checks++; if (retired !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d want %0d", retired, 0); end
`endif
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_sequential();
        @(negedge clock);
        icode = 4'h1;
        valid = 1'b1;
        stall = 1'b0;
        #1;
        checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL seq_latency: got %h want %h", pc, 16'h0000); end
        @(posedge clock);
        #1;
        valid = 1'b0;
        checks++; if (pc !== 16'h0001) begin errors++; $display("FAIL seq_nop: got %h want %h", pc, 16'h0001); end
        issue(4'h3, 16'h0000, 1'b0);
        checks++; if (pc !== 16'h000B) begin errors++; $display("FAIL seq_irmovq: got %h want %h", pc, 16'h000B); end
        issue(4'h6, 16'h0000, 1'b0);
        checks++; if (pc !== 16'h000D) begin errors++; $display("FAIL seq_opq: got %h want %h", pc, 16'h000D); end
        @(posedge clock);
        #1;
        checks++; if (pc !== 16'h000D) begin errors++; $display("FAIL seq_idle_hold: got %h want %h", pc, 16'h000D); end
        checks++; if (status !== 2'b00) begin errors++; $display("FAIL seq_status: got %b want %b", status, 2'b00); end
`ifdef PC_RETIRED_COUNT_EN
        checks++; if (retired !== 32'd3) begin errors++; $display("FAIL seq_count: got %0d want %0d", retired, 3); end
`endif
    endtask

    task automatic test_jump();
        issue(4'h7, 16'h0040, 1'b0);
        checks++; if (pc !== 16'h0016) begin errors++; $display("FAIL jmp_not_taken: got %h want %h", pc, 16'h0016); end
        issue(4'h7, 16'h0040, 1'b1);
        checks++; if (pc !== 16'h0040) begin errors++; $display("FAIL jmp_taken: got %h want %h", pc, 16'h0040); end
    endtask

    task automatic test_call_ret();
        issue(4'h8, 16'h0100, 1'b0);
        checks++; if (pc !== 16'h0100) begin errors++; $display("FAIL call_pc: got %h want %h", pc, 16'h0100); end
        checks++; if (depth !== 3'd1) begin errors++; $display("FAIL call_depth: got %0d want %0d", depth, 1); end
        issue(4'h9, 16'h0000, 1'b0);
        checks++; if (pc !== 16'h0049) begin errors++; $display("FAIL ret_pc: got %h want %h", pc, 16'h0049); end
        checks++; if (depth !== 3'd0) begin errors++; $display("FAIL ret_depth: got %0d want %0d", depth, 0); end
        issue(4'h9, 16'h0000, 1'b0);
        checks++; if (status !== 2'b11) begin errors++; $display("FAIL ret_empty_status: got %b want %b", status, 2'b11); end
        checks++; if (pc !== 16'h0049) begin errors++; $display("FAIL ret_empty_pc: got %h want %h", pc, 16'h0049); end
        issue(4'h1, 16'h0000, 1'b0);
        checks++; if (pc !== 16'h0049) begin errors++; $display("FAIL error_frozen_pc: got %h want %h", pc, 16'h0049); end
        checks++; if (status !== 2'b11) begin errors++; $display("FAIL error_frozen_status: got %b want %b", status, 2'b11); end
    endtask

    task automatic test_ras_overflow();
        logic [15:0] target;
        apply_reset();
        checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL ovf_reset_pc: got %h want %h", pc, 16'h0000); end
        for (int i = 1; i <= 4; i++) begin
            target = 16'(i) << 12;
            issue(4'h8, target, 1'b0);
            checks++; if (pc !== target) begin errors++; $display("FAIL ovf_call%0d_pc: got %h want %h", i, pc, target); end
            checks++; if (depth !== 3'(i)) begin errors++; $display("FAIL ovf_call%0d_depth: got %0d want %0d", i, depth, i); end
        end
        issue(4'h8, 16'h5000, 1'b0);
        checks++; if (status !== 2'b11) begin errors++; $display("FAIL ovf_status: got %b want %b", status, 2'b11); end
        checks++; if (pc !== 16'h4000) begin errors++; $display("FAIL ovf_pc: got %h want %h", pc, 16'h4000); end
        checks++; if (depth !== 3'd4) begin errors++; $display("FAIL ovf_depth: got %0d want %0d", depth, 4); end
    endtask

    task automatic test_ras_lifo();
        apply_reset();
        issue(4'h1, 16'h0000, 1'b0);
        issue(4'h8, 16'h0200, 1'b0);
        issue(4'h8, 16'h0300, 1'b0);
        checks++; if (pc !== 16'h0300) begin errors++; $display("FAIL lifo_call_pc: got %h want %h", pc, 16'h0300); end
        issue(4'h9, 16'h0000, 1'b0);
        checks++; if (pc !== 16'h0209) begin errors++; $display("FAIL lifo_ret_inner: got %h want %h", pc, 16'h0209); end
        checks++; if (depth !== 3'd1) begin errors++; $display("FAIL lifo_depth_inner: got %0d want %0d", depth, 1); end
        issue(4'h9, 16'h0000, 1'b0);
        checks++; if (pc !== 16'h000A) begin errors++; $display("FAIL lifo_ret_outer: got %h want %h", pc, 16'h000A); end
        checks++; if (status !== 2'b00) begin errors++; $display("FAIL lifo_status: got %b want %b", status, 2'b00); end
    endtask

    task automatic test_stall_wrap();
        apply_reset();
        issue(4'h7, 16'hFFFE, 1'b1);
        @(negedge clock);
        icode = 4'h3;
        valid = 1'b1;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            checks++; if (pc !== 16'hFFFE) begin errors++; $display("FAIL stall_hold%0d: got %h want %h", i, pc, 16'hFFFE); end
        end
        @(negedge clock);
        stall = 1'b0;
        @(posedge clock);
        #1;
        valid = 1'b0;
        checks++; if (pc !== 16'h0008) begin errors++; $display("FAIL wrap_pc: got %h want %h", pc, 16'h0008); end
        issue(4'hD, 16'h0000, 1'b0);
        checks++; if (status !== 2'b10) begin errors++; $display("FAIL illegal_status: got %b want %b", status, 2'b10); end
        checks++; if (pc !== 16'h0008) begin errors++; $display("FAIL illegal_pc: got %h want %h", pc, 16'h0008); end
    endtask

    task automatic test_return_wrap();
        apply_reset();
        issue(4'h7, 16'hFFF8, 1'b1);
        issue(4'h8, 16'h0050, 1'b0);
        issue(4'h9, 16'h0000, 1'b0);
        checks++; if (pc !== 16'h0001) begin errors++; $display("FAIL ret_wrap_pc: got %h want %h", pc, 16'h0001); end
    endtask

    task automatic test_halt_reset();
        apply_reset();
        issue(4'h7, 16'h0008, 1'b1);
        issue(4'h0, 16'h0000, 1'b0);
        checks++; if (status !== 2'b01) begin errors++; $display("FAIL halt_status: got %b want %b", status, 2'b01); end
        checks++; if (pc !== 16'h0008) begin errors++; $display("FAIL halt_pc: got %h want %h", pc, 16'h0008); end
        issue(4'h3, 16'h0000, 1'b0);
        checks++; if (pc !== 16'h0008) begin errors++; $display("FAIL halt_frozen_pc: got %h want %h", pc, 16'h0008); end
`ifdef PC_RETIRED_COUNT_EN
        checks++; if (retired !== 32'd2) begin errors++; $display("FAIL halt_count: got %0d want %0d", retired, 2); end
`endif
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL async_reset_pc: got %h want %h", pc, 16'h0000); end
        checks++; if (status !== 2'b00) begin errors++; $display("FAIL async_reset_status: got %b want %b", status, 2'b00); end
`ifdef PC_RETIRED_COUNT_EN
        checks++; if (retired !== 32'd0) begin errors++; $display("FAIL async_reset_count: got %0d want %0d", retired, 0); end
`endif
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        icode = 4'h0;
        valc  = 16'h0000;
        cond  = 1'b0;
        valid = 1'b0;
        stall = 1'b0;
        test_reset();
        test_sequential();
        test_jump();
        test_call_ret();
        test_ras_overflow();
        test_ras_lifo();
        test_stall_wrap();
        test_return_wrap();
        test_halt_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
